uart_word_tx: RTL and testbench

UART_WORD_TX -- requirements
Module: uart_word_tx

---
 rtl/sparse_comm_pkg.sv | 15 +
 rtl/uart_baud_gen.sv | 17 +
 rtl/uart_word_tx.sv | 115 +++++++++++
 tb/tb_uart_word_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_comm_pkg.sv
// sparse_comm_pkg: shared word/byte widths and the UART tx state type (PARITY state only with UART_TX_PARITY_EN)
package sparse_comm_pkg;
  localparam int WORD_W = 136;
  localparam int BYTE_W = 8;
  localparam int DEF_NUM_BYTES = WORD_W / BYTE_W;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } tx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period down-counter, one-cycle bit_tick every CLKS_PER_BIT cycles, realigned by clear
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);
  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);
  logic [15:0] cnt;
  assign bit_tick = cnt == 16'd0;
  // reload at every bit boundary and whenever a new word is accepted
  always_ff @(posedge clk)
    if (reset) cnt <= 16'd0;
    else cnt <= (clear || bit_tick) ? RELOAD : cnt - 16'd1;
endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a NUM_BYTES-byte word as back-to-back 8N1 frames, LSB byte first; UART_TX_PARITY_EN adds even parity
module uart_word_tx
  import sparse_comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES = DEF_NUM_BYTES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_BYTES*BYTE_W-1:0] data,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_complete
);
  localparam int BCW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);
  tx_state_t state;
  logic [NUM_BYTES*BYTE_W-1:0] sreg;
  logic [BCW-1:0] byte_cnt;
  logic [2:0] bit_cnt;
  logic accept;
  logic bit_tick;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  assign accept = start && !busy;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
    .clk(clk),
    .reset(reset),
    .clear(accept),
    .bit_tick(bit_tick)
  );
  // frame sequencer: the word shifts out LSB first, so sreg[0] is always the next data bit
  always_ff @(posedge clk)
    if (reset) begin
      state       <= S_IDLE;
      tx          <= 1'b1;
      busy        <= 1'b0;
      tx_complete <= 1'b0;
      sreg        <= '0;
      byte_cnt    <= '0;
      bit_cnt     <= '0;
`ifdef UART_TX_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      tx_complete <= 1'b0;
      case (state)
        S_IDLE:
          if (accept) begin
            sreg     <= data;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            tx       <= 1'b0;
            state    <= S_START;
          end
        S_START:
          if (bit_tick) begin
            tx    <= sreg[0];
            sreg  <= sreg >> 1;
`ifdef UART_TX_PARITY_EN
            par   <= sreg[0];
`endif
            state <= S_DATA;
          end
        S_DATA:
          if (bit_tick) begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= par;
              state   <= S_PARITY;
`else
              tx      <= 1'b1;
              state   <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= sreg[0];
              sreg    <= sreg >> 1;
`ifdef UART_TX_PARITY_EN
              par     <= par ^ sreg[0];
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
        S_PARITY:
          if (bit_tick) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
`endif
        S_STOP:
          if (bit_tick) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt    <= '0;
              busy        <= 1'b0;
              tx_complete <= 1'b1;
              state       <= S_IDLE;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
              tx       <= 1'b0;
              state    <= S_START;
            end
          end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: randomized self-checking bench against a bit-list UART frame model (UART_TX_PARITY_EN aware)
module tb_uart_word_tx;
  localparam int C = 4;
  localparam int N = 2;
  localparam int N17 = 17;
  localparam int DW = N * 8;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int L = N * F * C;
  localparam int L17 = N17 * F * C;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [DW-1:0] data = '0;
  logic tx, busy, tx_complete;
  logic start17 = 1'b0;
  logic [N17*8-1:0] data17 = '0;
  logic tx17, busy17, done17;
  int checks = 0;
  int fails = 0;
  bit exp_bits[$];

  always #5 clk = ~clk;

  uart_word_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .tx(tx), .busy(busy), .tx_complete(tx_complete)
  );

  uart_word_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(N17)) dut17 (
    .clk(clk), .reset(reset), .start(start17), .data(data17),
    .tx(tx17), .busy(busy17), .tx_complete(done17)
  );

  // a low line always means a word is in flight
  always @(negedge clk)
    if (!reset) begin
      checks++;
      if (tx === 1'b0 && busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_vs_tx: tx=%b busy=%b, required busy=1 while tx low", tx, busy);
      end
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // the line as a list of bits: start, 8 data LSB first, [even parity], stop per byte
  function automatic void build(input logic [135:0] w, input int nb);
    logic [7:0] by;
    exp_bits.delete();
    for (int b = 0; b < nb; b++) begin
      by = w[b*8 +: 8];
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(by[i]);
      if (F == 11) exp_bits.push_back(^by);
      exp_bits.push_back(1'b1);
    end
  endfunction

  task automatic kick(input logic [DW-1:0] d);
    @(negedge clk);
    start = 1'b1;
    data = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    data = DW'($urandom);
  endtask

  // entered just after the acceptance edge; returns in the tx_complete cycle
  task automatic check_word(input string name);
    for (int k = 0; k < L; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (tx !== exp_bits[k/C] || busy !== 1'b1 || tx_complete !== 1'b0) begin
        fails++;
        $display("FAIL %s cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                 name, k, tx, busy, tx_complete, exp_bits[k/C]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_complete !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL %s end: done=%b busy=%b tx=%b, required done=1 busy=0 tx=1",
               name, tx_complete, busy, tx);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    start17 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_complete !== 1'b0 || tx17 !== 1'b1 || busy17 !== 1'b0) begin
      fails++;
      $display("FAIL reset: tx=%b busy=%b done=%b tx17=%b busy17=%b, required 1 0 0 1 0",
               tx, busy, tx_complete, tx17, busy17);
    end
    start = 1'b0;
    start17 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_fixed();
    build(136'(16'hA55A), N);
    kick(16'hA55A);
    check_word("fixed_a55a");
    @(posedge clk);
    #1;
    checks++;
    if (tx_complete !== 1'b0) begin
      fails++;
      $display("FAIL done_one_cycle: done=%b, required 0", tx_complete);
    end
  endtask

  task automatic test_parity();
`ifdef UART_TX_PARITY_EN
    build(136'(16'h0301), N);
    kick(16'h0301);
    check_word("parity_0301");
`endif
  endtask

  task automatic test_ignored_start();
    logic [DW-1:0] d;
    d = DW'($urandom);
    build(136'(d), N);
    kick(d);
    fork
      check_word("ignored_start");
      begin
        repeat (19) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        data = ~d;
        @(negedge clk);
        start = 1'b0;
      end
    join
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    int bad;
    d = DW'($urandom);
    kick(d);
    repeat (29) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_complete !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: tx=%b busy=%b done=%b, required 1 0 0", tx, busy, tx_complete);
    end
    reset = 1'b0;
    bad = 0;
    repeat (L + 8) begin
      @(posedge clk);
      #1;
      if (tx_complete !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_quiet: %0d bad cycles after abort, required 0", bad);
    end
    d = DW'($urandom);
    build(136'(d), N);
    kick(d);
    check_word("after_reset");
  endtask

  task automatic test_random_gaps();
    logic [DW-1:0] d;
    int gap;
    for (int w = 0; w < 5; w++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || tx_complete !== 1'b0) begin
          fails++;
          $display("FAIL gap: busy=%b tx=%b done=%b, required 0 1 0", busy, tx, tx_complete);
        end
      end
      d = DW'($urandom);
      build(136'(d), N);
      kick(d);
      check_word("random_word");
    end
  endtask

  task automatic test_back_to_back();
    logic [N17*8-1:0] d1, d2;
    for (int i = 0; i < N17; i++) begin
      d1[i*8 +: 8] = 8'($urandom);
      d2[i*8 +: 8] = 8'($urandom);
    end
    @(negedge clk);
    start17 = 1'b1;
    data17 = d1;
    @(posedge clk);
    #1;
    data17 = d2;
    for (int w = 0; w < 2; w++) begin
      build(w == 0 ? d1 : d2, N17);
      for (int k = 0; k < L17; k++) begin
        if (k > 0) begin
          @(posedge clk);
          #1;
        end
        checks++;
        if (tx17 !== exp_bits[k/C] || busy17 !== 1'b1 || done17 !== 1'b0) begin
          fails++;
          $display("FAIL b2b word %0d cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                   w, k, tx17, busy17, done17, exp_bits[k/C]);
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (done17 !== 1'b1 || busy17 !== 1'b0 || tx17 !== 1'b1) begin
        fails++;
        $display("FAIL b2b end %0d: done=%b busy=%b tx=%b, required 1 0 1", w, done17, busy17, tx17);
      end
      if (w == 0) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    start17 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy17 !== 1'b0 || done17 !== 1'b0 || tx17 !== 1'b1) begin
      fails++;
      $display("FAIL b2b idle: busy=%b done=%b tx=%b, required 0 0 1", busy17, done17, tx17);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_parity();
    test_ignored_start();
    test_reset_mid();
    test_random_gaps();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
